bit_serializer: RTL and testbench
=================================

// Module: bit_serializer
// PURPOSE
//  Parallel-to-serial front end for the serial pattern-detector FSM.
//  Accepts a WIDTH-bit word through a load/ready handshake and presents it
//  one bit per clock on x, which drives the detector's x input directly.
//  Back-to-back words stream without gaps, so patterns that span a word
//  boundary are still seen by the detector.
// PARAMETERS
//  WIDTH      8   bits per word; legal range WIDTH >= 2
//  MSB_FIRST  1   1: data_in[WIDTH-1] is sent first; 0: data_in[0] is sent first
// PORTS
//  clk      in   1      system clock; all state changes on posedge
//  reset    in   1      synchronous, active-high reset
//  data_in  in   WIDTH  parallel word; sampled only on an accepted load
//  load     in   1      request to load data_in; accepted when load & ready
//  ready    out  1      block can accept a word on this clock edge
//  x        out  1      serial bit to the detector; 0 whenever x_valid = 0
//  x_valid  out  1      x carries a data bit this cycle
//  done     out  1      1-cycle pulse, high while the last bit of a word is on x
// BEHAVIOUR
//  - Reset (reset = 1 at posedge):
//    - state = IDLE, shift register = 0, bit counter = 0.
//    - x = 0, x_valid = 0, done = 0.
//    - ready is forced to 0 while reset = 1.
//    - Reset wins over a simultaneous load; the word is discarded.
//  - State machine has two states, IDLE and SHIFT. The counter has
//    ceil(log2(WIDTH)) bits.
//    - IDLE: ready = 1, x_valid = 0, x = 0.
//      On load: capture data_in, counter = 0, go to SHIFT.
//    - SHIFT: x_valid = 1.
//      - x = current head bit: MSB when MSB_FIRST = 1, LSB otherwise.
//      - Each posedge shifts the register by one bit and increments the counter.
//      - At counter == WIDTH-1 (last bit on x): done = 1, ready = 1.
//        - With load: reload data_in, counter = 0, stay in SHIFT.
//          The first bit of the new word appears the next cycle with no gap.
//        - Without load: go to IDLE.
//      - At counter < WIDTH-1: ready = 0. A load in this cycle is ignored and
//        not queued.
//  - Latency: load accepted at edge N means the first bit is on x after edge N,
//    and the last bit is on x after edge N+WIDTH-1.
//  - x, x_valid and done are registered (driven from state and register
//    contents only), so there is no combinational path from load/data_in to x.
//  - ready is a combinational decode of state and counter only; it never
//    depends on load.
//  - data_in changes while in SHIFT have no effect.
//  - Reset in mid-word aborts the word. The next cycle shows x_valid = 0 and
//    no done pulse.
// TESTING
//  1. reset = 1 for 2 cycles with load = 1 ->
//     x = 0, x_valid = 0, done = 0, ready = 0; no word is captured.
//  2. WIDTH = 8, MSB_FIRST = 1, load 8'b1101_0000 ->
//     - x = 1,1,0,1,0,0,0,0 on cycles 1..8 after the load, x_valid = 1 throughout.
//     - done = 1 on cycle 8 only; IDLE on cycle 9.
//     - The detector pulses y after the 4th bit.
//  3. Back-to-back: load 8'hB3, then load 8'h5A in its done cycle ->
//     16 consecutive valid bits 1011_0011_0101_1010, ready low except in
//     done cycles, two done pulses 8 cycles apart.
//  4. Load asserted in cycles 2..6 of an active word ->
//     ignored; output stream unchanged; only one done pulse.
//  5. MSB_FIRST = 0, load 8'b0000_1011 ->
//     x = 1,1,0,1,0,0,0,0 (LSB first).
//  6. reset = 1 after bit 3 of a word ->
//     next cycle x_valid = 0, ready = 0 during reset, ready = 1 after release;
//     a fresh load then serializes correctly.

Source files
------------

// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial front end for the serial pattern detector.
//   A WIDTH-bit word is accepted through a load/ready handshake and is
//   presented one bit per clock on x. A word loaded during the last-bit
//   cycle of the previous word follows with no gap, so the detector sees
//   one continuous bit stream across word boundaries.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no word in flight; x/x_valid/done low, ready high
//   SHIFT | word in flight; x carries the head bit, cnt_q = bits already
//         | sent; ready only on the last bit (cnt_q == WIDTH-1)
//
//   x, x_valid and done are flops loaded with the values for the next
//   cycle, so nothing combinational runs from load/data_in to the
//   detector. ready decodes state and counter only; the reset term keeps
//   ready low while reset is held.

module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             x,
  output logic             x_valid,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic             x_q;
  logic             x_valid_q;
  logic             done_q;

  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] shreg_adv;
  logic [CW-1:0]    cnt_adv;

  // Bit that is presented first from a given register image.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      return v[WIDTH-1];
    end
    return v[0];
  endfunction

  // Register image after the current head bit has been consumed.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      return {v[WIDTH-2:0], 1'b0};
    end
    return {1'b0, v[WIDTH-1:1]};
  endfunction

  // Handshake decode and next-bit arithmetic shared by the FSM.
  always_comb begin
    last_bit  = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    ready     = !reset && ((state_q == IDLE) || last_bit);
    accept    = load && ready;
    shreg_adv = advance(shreg_q);
    cnt_adv   = cnt_q + CW'(1);
  end

  // FSM: state, shift register, bit counter and the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= SHIFT;
            shreg_q   <= data_in;
            cnt_q     <= '0;
            x_q       <= head_bit(data_in);
            x_valid_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            if (accept) begin
              // Seamless reload: first bit of the new word follows directly.
              shreg_q   <= data_in;
              cnt_q     <= '0;
              x_q       <= head_bit(data_in);
              x_valid_q <= 1'b1;
              done_q    <= 1'b0;
            end else begin
              state_q   <= IDLE;
              shreg_q   <= '0;
              cnt_q     <= '0;
              x_q       <= 1'b0;
              x_valid_q <= 1'b0;
              done_q    <= 1'b0;
            end
          end else begin
            // Loads here are dropped; ready is low so nothing is accepted.
            shreg_q   <= shreg_adv;
            cnt_q     <= cnt_adv;
            x_q       <= head_bit(shreg_adv);
            x_valid_q <= 1'b1;
            done_q    <= (cnt_adv == LAST_CNT);
          end
        end
        default: begin
          state_q   <= IDLE;
          shreg_q   <= '0;
          cnt_q     <= '0;
          x_q       <= 1'b0;
          x_valid_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance share
// one stimulus stream and are compared against a word-level reference
// model (bits remaining in the current word plus the word itself).

module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         load;
  logic         ready_m, x_m, x_valid_m, done_m;
  logic         ready_l, x_l, x_valid_l, done_l;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int           rem = 0;
  logic [W-1:0] word = '0;

  // stream capture helpers
  logic [31:0] acc_m;
  logic [31:0] acc_l;
  int          done_seen;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load),
    .ready(ready_m), .x(x_m), .x_valid(x_valid_m), .done(done_m)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load),
    .ready(ready_l), .x(x_l), .x_valid(x_valid_l), .done(done_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, check ready, clock the model, check outputs.
  task automatic cycle(input logic rst, input logic ld, input logic [W-1:0] d);
    logic exp_ready;
    int   k;
    @(negedge clk);
    reset   = rst;
    load    = ld;
    data_in = d;
    #1;
    exp_ready = !rst && (rem <= 1);
    chk("ready_msb", {31'd0, ready_m}, {31'd0, exp_ready});
    chk("ready_lsb", {31'd0, ready_l}, {31'd0, exp_ready});
    @(posedge clk);
    if (rst) begin
      rem = 0;
    end else if (ld && exp_ready) begin
      word = d;
      rem  = W;
    end else if (rem > 0) begin
      rem = rem - 1;
    end
    #1;
    k = W - rem;
    chk("x_valid_msb", {31'd0, x_valid_m}, {31'd0, rem > 0});
    chk("x_valid_lsb", {31'd0, x_valid_l}, {31'd0, rem > 0});
    chk("done_msb", {31'd0, done_m}, {31'd0, rem == 1});
    chk("done_lsb", {31'd0, done_l}, {31'd0, rem == 1});
    chk("x_msb", {31'd0, x_m}, {31'd0, (rem > 0) ? word[W-1-k] : 1'b0});
    chk("x_lsb", {31'd0, x_l}, {31'd0, (rem > 0) ? word[k] : 1'b0});
    if (x_valid_m) acc_m = {acc_m[30:0], x_m};
    if (x_valid_l) acc_l = {acc_l[30:0], x_l};
    if (done_m) done_seen++;
  endtask

  task automatic clear_capture();
    acc_m     = '0;
    acc_l     = '0;
    done_seen = 0;
  endtask

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    data_in = '0;

    // reset held with load high: nothing captured, ready low
    cycle(1'b1, 1'b1, 8'hFF);
    cycle(1'b1, 1'b1, 8'hFF);
    cycle(1'b0, 1'b0, 8'h00);

    // single word, then return to idle
    clear_capture();
    cycle(1'b0, 1'b1, 8'b1101_0000);
    repeat (9) cycle(1'b0, 1'b0, 8'h00);
    chk("word_d0_msb", acc_m, 32'h0000_00D0);
    chk("word_d0_lsb", acc_l, 32'h0000_000B);
    chk("word_d0_done", done_seen, 1);

    // back-to-back words loaded in the done cycle
    clear_capture();
    cycle(1'b0, 1'b1, 8'hB3);
    repeat (7) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h5A);
    repeat (8) cycle(1'b0, 1'b0, 8'h00);
    chk("b2b_stream", acc_m, 32'h0000_B35A);
    chk("b2b_done", done_seen, 2);

    // loads during cycles 2..6 of a word are ignored
    clear_capture();
    cycle(1'b0, 1'b1, 8'h96);
    cycle(1'b0, 1'b0, 8'h00);
    repeat (5) cycle(1'b0, 1'b1, 8'h3C);
    repeat (4) cycle(1'b0, 1'b0, 8'h00);
    chk("ignore_stream", acc_m, 32'h0000_0096);
    chk("ignore_done", done_seen, 1);

    // LSB-first instance on 0000_1011
    clear_capture();
    cycle(1'b0, 1'b1, 8'b0000_1011);
    repeat (8) cycle(1'b0, 1'b0, 8'h00);
    chk("lsb_stream", acc_l, 32'h0000_00D0);

    // reset after bit 3 aborts the word, fresh word follows
    cycle(1'b0, 1'b1, 8'hE7);
    repeat (2) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h11);
    cycle(1'b0, 1'b0, 8'h00);
    clear_capture();
    cycle(1'b0, 1'b1, 8'hC5);
    repeat (8) cycle(1'b0, 1'b0, 8'h00);
    chk("post_reset_stream", acc_m, 32'h0000_00C5);
    chk("post_reset_done", done_seen, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
